// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, issues word requests to busio, and feeds
// decode through output registers backed by a one-entry skid buffer.
module fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  input  logic        mret,
  input  logic [31:0] mret_address,
  input  logic        traped,
  input  logic [31:0] trap_address,
  output logic        fetch_request,
  output logic [31:0] fetch_address,
  input  logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        instruction_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] next_pc
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;

  logic            run_q, run_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] disc_addr_q, disc_addr_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_data_q, skid_data_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_insn_q, out_insn_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            accept;

  // Redirect target selection and bus-side request generation
  always_comb begin
    redirect = traped | mret | branch_taken;
    if (traped)    target = trap_address;
    else if (mret) target = mret_address;
    else           target = branch_address;
    target = {target[XLEN-1:2], 2'b00};

    fetch_request = run_q & (~skid_valid_q | discard_q);
    // an orphaned request keeps its original address until its response returns
    fetch_address = discard_q ? disc_addr_q : fetch_pc_q;
    accept        = fetch_request & fetch_ready & ~discard_q & ~redirect;
  end

  // Next-state for PC, discard tracking, skid and decode-facing registers
  always_comb begin
    run_d        = 1'b1;
    fetch_pc_d   = fetch_pc_q;
    discard_d    = discard_q;
    disc_addr_d  = disc_addr_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_pc_d    = skid_pc_q;
    out_valid_d  = out_valid_q;
    out_insn_d   = out_insn_q;
    out_pc_d     = out_pc_q;

    if (redirect) begin
      fetch_pc_d = target;
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + WORD_BYTES;
    end

    if (redirect && fetch_request && !fetch_ready) begin
      discard_d   = 1'b1;
      disc_addr_d = fetch_address;
    end else if (fetch_ready) begin
      discard_d = 1'b0;
    end

    if (redirect) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (stall) begin
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_data_d  = fetch_data;
        skid_pc_d    = fetch_pc_q;
      end
    end else if (skid_valid_q) begin
      out_valid_d  = 1'b1;
      out_insn_d   = skid_data_q;
      out_pc_d     = skid_pc_q;
      skid_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_insn_d  = fetch_data;
      out_pc_d    = fetch_pc_q;
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q        <= 1'b0;
      fetch_pc_q   <= RESET_VECTOR;
      discard_q    <= 1'b0;
      disc_addr_q  <= RESET_VECTOR;
      skid_valid_q <= 1'b0;
      skid_data_q  <= NOP_INSN;
      skid_pc_q    <= RESET_VECTOR;
      out_valid_q  <= 1'b0;
      out_insn_q   <= NOP_INSN;
      out_pc_q     <= RESET_VECTOR;
    end else begin
      run_q        <= run_d;
      fetch_pc_q   <= fetch_pc_d;
      discard_q    <= discard_d;
      disc_addr_q  <= disc_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      out_insn_q   <= out_insn_d;
      out_pc_q     <= out_pc_d;
    end
  end

  assign instruction_valid = out_valid_q;
  assign instruction       = out_insn_q;
  assign pc                = out_pc_q;
  assign next_pc           = out_pc_q + WORD_BYTES;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, hand-written redirect/reset sequences,
// then randomized traffic checked against a rule-level reference model.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, branch_taken, mret, traped, fetch_ready;
  logic [31:0] branch_address, mret_address, trap_address, fetch_data;
  logic        fetch_request, instruction_valid;
  logic [31:0] fetch_address, instruction, pc, next_pc;

  int errors = 0;
  int checks = 0;

  fetch dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .mret(mret), .mret_address(mret_address),
    .traped(traped), .trap_address(trap_address),
    .fetch_request(fetch_request), .fetch_address(fetch_address),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .instruction_valid(instruction_valid), .instruction(instruction),
    .pc(pc), .next_pc(next_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; mret = 0; traped = 0; fetch_ready = 0;
    branch_address = 0; mret_address = 0; trap_address = 0; fetch_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        stall;
    logic        ready;
    logic        br;
    logic [31:0] br_addr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[17];

  // ---------------- reference model (spec-level rules) ----------------
  logic        m_run, m_disc, m_valid;
  logic [31:0] m_fpc, m_daddr, m_insn, m_pc;
  logic [63:0] m_skid[$];

  function automatic logic m_req();
    return m_run && (m_skid.size() == 0 || m_disc);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_disc ? m_daddr : m_fpc;
  endfunction

  task automatic m_reset();
    m_run = 0; m_disc = 0; m_valid = 0; m_fpc = 0; m_daddr = 0;
    m_insn = 32'h13; m_pc = 0; m_skid.delete();
  endtask

  task automatic m_step();
    logic redir, acc, req;
    logic [31:0] tgt, cur;
    req   = m_req();
    cur   = m_addr();
    redir = traped | mret | branch_taken;
    tgt   = traped ? trap_address : (mret ? mret_address : branch_address);
    tgt   = tgt & 32'hFFFF_FFFC;
    acc   = req && fetch_ready && !m_disc && !redir;
    if (redir && req && !fetch_ready) begin
      m_disc = 1; m_daddr = cur;
    end else if (fetch_ready) begin
      m_disc = 0;
    end
    if (redir) begin
      m_valid = 0; m_skid.delete();
    end else if (stall) begin
      if (acc) m_skid.push_back({fetch_data, m_fpc});
    end else if (m_skid.size() != 0) begin
      m_valid = 1; m_insn = m_skid[0][63:32]; m_pc = m_skid[0][31:0];
      m_skid.pop_front();
    end else if (acc) begin
      m_valid = 1; m_insn = fetch_data; m_pc = m_fpc;
    end else begin
      m_valid = 0;
    end
    if (redir)    m_fpc = tgt;
    else if (acc) m_fpc = m_fpc + 32'd4;
    m_run = 1;
  endtask

  task automatic m_compare();
    chk("rnd_req", {31'b0, fetch_request}, {31'b0, m_req()});
    if (m_req()) chk("rnd_addr", fetch_address, m_addr());
    chk("rnd_valid", {31'b0, instruction_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("rnd_pc", pc, m_pc);
      chk("rnd_insn", instruction, m_insn);
    end
    chk("rnd_next_pc", next_pc, pc + 32'd4);
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;

    tbl[0]  = '{0, 1, 0, 0,      1, 32'h00,  0, 32'h00};
    tbl[1]  = '{0, 1, 0, 0,      1, 32'h04,  1, 32'h00};
    tbl[2]  = '{0, 1, 0, 0,      1, 32'h08,  1, 32'h04};
    tbl[3]  = '{0, 1, 0, 0,      1, 32'h0C,  1, 32'h08};
    tbl[4]  = '{1, 1, 0, 0,      1, 32'h10,  1, 32'h0C};
    tbl[5]  = '{1, 0, 0, 0,      0, 32'h14,  1, 32'h0C};
    tbl[6]  = '{1, 0, 0, 0,      0, 32'h14,  1, 32'h0C};
    tbl[7]  = '{0, 0, 0, 0,      0, 32'h14,  1, 32'h0C};
    tbl[8]  = '{0, 1, 0, 0,      1, 32'h14,  1, 32'h10};
    tbl[9]  = '{0, 0, 0, 0,      1, 32'h18,  1, 32'h14};
    tbl[10] = '{0, 0, 0, 0,      1, 32'h18,  0, 32'h00};
    tbl[11] = '{0, 0, 1, 32'h200, 1, 32'h18, 0, 32'h00};
    tbl[12] = '{0, 0, 0, 0,      1, 32'h18,  0, 32'h00};
    tbl[13] = '{0, 1, 0, 0,      1, 32'h18,  0, 32'h00};
    tbl[14] = '{0, 1, 0, 0,      1, 32'h200, 0, 32'h00};
    tbl[15] = '{0, 0, 0, 0,      1, 32'h204, 1, 32'h200};
    tbl[16] = '{0, 0, 0, 0,      1, 32'h204, 0, 32'h00};

    // reset state
    #12;
    chk("rst_req", {31'b0, fetch_request}, 32'd0);
    chk("rst_valid", {31'b0, instruction_valid}, 32'd0);
    chk("rst_insn", instruction, 32'h13);
    chk("rst_pc", pc, 32'h0);
    chk("rst_next_pc", next_pc, 32'h4);
    @(negedge clk);
    reset_n = 1;
    tick();

    // streaming, stall with skid capture, branch over a pending request
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("vec%0d_req", i), {31'b0, fetch_request}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), fetch_address, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, instruction_valid}, {31'b0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_insn", i), instruction, tbl[i].e_pc);
      end
      stall = tbl[i].stall; fetch_ready = tbl[i].ready;
      branch_taken = tbl[i].br; branch_address = tbl[i].br_addr;
      fetch_data = tbl[i].e_addr;
      tick();
    end
    idle_inputs();

    // trap and branch together while 0x204 is pending: trap wins
    traped = 1; trap_address = 32'h100; branch_taken = 1; branch_address = 32'h300;
    tick();
    idle_inputs();
    chk("trap_valid", {31'b0, instruction_valid}, 32'd0);
    chk("trap_hold_addr", fetch_address, 32'h204);
    fetch_ready = 1; fetch_data = 32'hDEAD_BEEF;
    tick();
    chk("trap_addr", fetch_address, 32'h100);
    chk("trap_drop_valid", {31'b0, instruction_valid}, 32'd0);
    fetch_data = 32'h100;
    tick();
    chk("trap_first_valid", {31'b0, instruction_valid}, 32'd1);
    chk("trap_first_pc", pc, 32'h100);

    // mret coinciding with a response, misaligned target
    fetch_ready = 1; fetch_data = 32'hBAD0_0BAD; mret = 1; mret_address = 32'h81;
    tick();
    mret = 0;
    chk("mret_valid", {31'b0, instruction_valid}, 32'd0);
    chk("mret_req", {31'b0, fetch_request}, 32'd1);
    chk("mret_addr", fetch_address, 32'h80);
    fetch_data = 32'h80;
    tick();
    chk("mret_nodiscard_valid", {31'b0, instruction_valid}, 32'd1);
    chk("mret_nodiscard_pc", pc, 32'h80);

    // wrap of the fetch PC past 0xFFFF_FFFC
    branch_taken = 1; branch_address = 32'hFFFF_FFFC; fetch_data = 32'h0;
    tick();
    branch_taken = 0;
    chk("wrap_addr0", fetch_address, 32'hFFFF_FFFC);
    fetch_data = 32'h1234_5678;
    tick();
    chk("wrap_addr1", fetch_address, 32'h0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_insn", instruction, 32'h1234_5678);
    chk("wrap_next_pc", next_pc, 32'h0);

    // reset in the middle of a pending transaction
    fetch_ready = 0;
    #2 reset_n = 0;
    #1;
    chk("midrst_req", {31'b0, fetch_request}, 32'd0);
    chk("midrst_valid", {31'b0, instruction_valid}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    chk("midrst_insn", instruction, 32'h13);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    tick();
    chk("restart_req", {31'b0, fetch_request}, 32'd1);
    chk("restart_addr", fetch_address, 32'h0);
    chk("restart_valid", {31'b0, instruction_valid}, 32'd0);

    // randomized traffic against the reference model
    idle_inputs();
    reset_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    m_step();
    for (int c = 0; c < 3000; c++) begin
      tick();
      m_compare();
      stall       = ($urandom_range(0, 9) < 3);
      fetch_ready = m_req() ? 1'($urandom_range(0, 1)) : 1'b0;
      fetch_data  = $urandom;
      branch_taken = ($urandom_range(0, 99) < 5);
      mret         = ($urandom_range(0, 99) < 3);
      traped       = ($urandom_range(0, 99) < 3);
      branch_address = $urandom;
      mret_address   = $urandom;
      trap_address   = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : 32'hFFFF_FFFC;
      m_step();
    end
    tick();
    m_compare();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
